// File: rtl/rojobot_motion_sequencer.sv
// Rojobot motion sequencer: queues timed motion commands and drives the robot
// control byte. It also synchronizes the robot update pulse and keeps the
// sticky update interrupt flag that the CPU clears with int_ack.
module rojobot_motion_sequencer #(
    parameter int unsigned FIFO_AW   = 2,
    parameter logic [7:0]  IDLE_CTRL = 8'h00
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               cmd_wr,
    input  logic [15:0]        cmd_wdata,
    input  logic               abort,
    input  logic               bot_upd,
    input  logic               int_ack,
    output logic [7:0]         bot_ctrl,
    output logic               upd_flag,
    output logic               busy,
    output logic [FIFO_AW:0]   cmd_count,
    output logic               cmd_full,
    output logic               overflow
);

    localparam int unsigned    DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE  = (FIFO_AW+1)'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Update pulse synchronizer and edge detect
    logic sync1_q, sync2_q, sync3_q;
    logic upd_evt;

    // Sticky interrupt flag
    logic upd_flag_q, upd_flag_d;

    // Command FIFO
    logic [15:0]      mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] count;
    logic             full, empty, push, pop;
    logic [15:0]      head;
    logic             overflow_q, overflow_d;

    // Sequencer state
    state_t     state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic       cont_q, cont_d;
    logic [7:0] bot_ctrl_q, bot_ctrl_d;

    // Two-flop synchronizer followed by an edge register for bot_upd
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bot_upd;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign upd_evt = sync2_q & ~sync3_q;

    // Set has priority over acknowledge so an update is never lost
    assign upd_flag_d = upd_evt | (upd_flag_q & ~int_ack);

    // FIFO status derived from pointers with an extra wrap bit
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign push  = cmd_wr & ~full & ~abort;

    // Overflow is sticky until abort; a write dropped by abort does not count
    assign overflow_d = abort ? 1'b0 : (overflow_q | (cmd_wr & full));

    // Pointer update; abort empties the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Sequencer next-state: pick up commands, count update events, chain back-to-back
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        bot_ctrl_d  = bot_ctrl_q;
        pop         = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
            cont_d      = 1'b0;
            bot_ctrl_d  = IDLE_CTRL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bot_ctrl_d = IDLE_CTRL;
                    if (!empty) pop = 1'b1;
                end
                S_RUN: begin
                    if (cont_q) begin
                        if (!empty) pop = 1'b1;
                    end else if (upd_evt) begin
                        if (remaining_q == 8'd1) begin
                            if (!empty) begin
                                pop = 1'b1;
                            end else begin
                                state_d     = S_IDLE;
                                remaining_d = '0;
                                bot_ctrl_d  = IDLE_CTRL;
                            end
                        end else begin
                            remaining_d = remaining_q - 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // A popped command overrides whatever the current state decided
            if (pop) begin
                state_d     = S_RUN;
                bot_ctrl_d  = head[7:0];
                remaining_d = head[15:8];
                cont_d      = (head[15:8] == 8'd0);
            end
        end
    end

    // FIFO storage needs no reset; entries are only read when valid
    always_ff @(posedge HCLK) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= cmd_wdata;
    end

    // Registered state, pointers and outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cont_q      <= 1'b0;
            bot_ctrl_q  <= IDLE_CTRL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            upd_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cont_q      <= cont_d;
            bot_ctrl_q  <= bot_ctrl_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            upd_flag_q  <= upd_flag_d;
        end
    end

    assign bot_ctrl  = bot_ctrl_q;
    assign upd_flag  = upd_flag_q;
    assign busy      = (state_q == S_RUN);
    assign cmd_count = count;
    assign cmd_full  = full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rojobot_motion_sequencer.sv
// Randomized self-checking bench for rojobot_motion_sequencer. A
// transaction-level model (command queue plus active-command record) predicts
// every output after each clock edge.
module tb_rojobot_motion_sequencer;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_wr;
    logic [15:0] cmd_wdata;
    logic        abort;
    logic        bot_upd;
    logic        int_ack;
    logic [7:0]  bot_ctrl;
    logic        upd_flag;
    logic        busy;
    logic [2:0]  cmd_count;
    logic        cmd_full;
    logic        overflow;

    rojobot_motion_sequencer #(
        .FIFO_AW   (2),
        .IDLE_CTRL (8'h00)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_wr    (cmd_wr),
        .cmd_wdata (cmd_wdata),
        .abort     (abort),
        .bot_upd   (bot_upd),
        .int_ack   (int_ack),
        .bot_ctrl  (bot_ctrl),
        .upd_flag  (upd_flag),
        .busy      (busy),
        .cmd_count (cmd_count),
        .cmd_full  (cmd_full),
        .overflow  (overflow)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_q[$];
    int          m_evt_edges[$];
    bit          m_active;
    bit          m_cont;
    int          m_rem;
    logic [7:0]  m_ctrl;
    bit          m_ovf;
    bit          m_flag;
    int          edge_n;
    bit          prev_s;
    int          upd_cnt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("bot_ctrl",  16'(bot_ctrl),  16'(m_ctrl));
        check("busy",      16'(busy),      16'(m_active));
        check("upd_flag",  16'(upd_flag),  16'(m_flag));
        check("cmd_count", 16'(cmd_count), 16'(m_q.size()));
        check("cmd_full",  16'(cmd_full),  16'(m_q.size() == 4));
        check("overflow",  16'(overflow),  16'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_evt_edges.delete();
        m_active = 0;
        m_cont   = 0;
        m_rem    = 0;
        m_ctrl   = 8'h00;
        m_ovf    = 0;
        m_flag   = 0;
        prev_s   = 0;
    endtask

    // Predict the effect of the coming clock edge given the current inputs
    task automatic model_step();
        bit         evt;
        bit         do_pop;
        bit         was_full;
        logic [15:0] c;
        evt = (m_evt_edges.size() > 0) && (m_evt_edges[0] == edge_n);
        if (evt) void'(m_evt_edges.pop_front());
        // A rising edge of bot_upd sampled now takes effect two edges later
        if (bot_upd && !prev_s) m_evt_edges.push_back(edge_n + 2);
        prev_s = bot_upd;
        edge_n++;

        if (evt) m_flag = 1;
        else if (int_ack) m_flag = 0;

        if (abort) begin
            m_q.delete();
            m_active = 0;
            m_cont   = 0;
            m_rem    = 0;
            m_ctrl   = 8'h00;
            m_ovf    = 0;
            return;
        end

        do_pop = 0;
        if (!m_active || m_cont) begin
            do_pop = (m_q.size() > 0);
        end else if (evt) begin
            if (m_rem == 1) begin
                do_pop = (m_q.size() > 0);
                if (!do_pop) begin
                    m_active = 0;
                    m_rem    = 0;
                    m_ctrl   = 8'h00;
                end
            end else begin
                m_rem--;
            end
        end

        was_full = (m_q.size() == 4);
        c = 16'h0;
        if (do_pop) c = m_q.pop_front();
        if (cmd_wr) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back(cmd_wdata);
        end
        if (do_pop) begin
            m_active = 1;
            m_ctrl   = c[7:0];
            m_rem    = int'(c[15:8]);
            m_cont   = (c[15:8] == 8'd0);
        end
    endtask

    // One clock of random stimulus, prediction and comparison
    task automatic run_cycles(input int n, input int p_wr, input int p_ab);
        logic [7:0] t;
        for (int i = 0; i < n; i++) begin
            cmd_wr  = ($urandom_range(99) < p_wr);
            t       = ($urandom_range(9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            cmd_wdata = {t, 8'($urandom)};
            abort   = ($urandom_range(99) < p_ab);
            int_ack = ($urandom_range(5) == 0);
            if (upd_cnt == 0) begin
                bot_upd = ~bot_upd;
                upd_cnt = bot_upd ? $urandom_range(2, 3) : $urandom_range(1, 5);
            end
            upd_cnt--;
            model_step();
            @(posedge HCLK);
            #1;
            check_all();
        end
    endtask

    initial begin
        HRESETn   = 1'b0;
        cmd_wr    = 1'b0;
        cmd_wdata = 16'h0;
        abort     = 1'b0;
        bot_upd   = 1'b0;
        int_ack   = 1'b0;
        upd_cnt   = 3;
        edge_n    = 0;
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        check_all();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #4;

        run_cycles(300, 20, 0);
        run_cycles(400, 60, 2);
        run_cycles(300, 5, 1);
        run_cycles(300, 35, 1);

        // Fill the queue while running, then reset asynchronously mid-cycle
        run_cycles(10, 90, 0);
        #2;
        HRESETn = 1'b0;
        bot_upd = 1'b0;
        cmd_wr  = 1'b0;
        abort   = 1'b0;
        int_ack = 1'b0;
        upd_cnt = 3;
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge HCLK);
        #1;
        check_all();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #4;
        run_cycles(20, 0, 0);
        run_cycles(300, 30, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
